// File: rtl/mram_pkg.sv
// Shared state type, widths and timing defaults for the MRAM bus controller.
package mram_pkg;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned DEV_ADDR_W = 16;
  localparam int unsigned TCNT_W     = 4;

  localparam int unsigned T_ACC_DEF = 4;
  localparam int unsigned T_SU_DEF  = 4;
  localparam int unsigned T_HLD_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    RD_DONE,
    WR_SU,
    WR_PULSE,
    WR_HLD,
    TURN
  } mram_state_e;

  // A phase of N cycles is timed by loading N-1 and leaving when the timer reads zero.
  function automatic logic [TCNT_W-1:0] phase_load(input int unsigned cycles);
    return TCNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/mram_tcount.sv
// Phase timer: loads a cycle count, decrements to zero and flags zero.
module mram_tcount
  import mram_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [TCNT_W-1:0] i_load_val,
  output logic              o_zero
);

  logic [TCNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TCNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mram_bus_ctrl.sv
// Request/response front end driving an asynchronous MRAM with programmable
// setup, strobe and hold phases; every device-facing output is registered.
module mram_bus_ctrl
  import mram_pkg::*;
#(
  parameter int unsigned T_ACC = T_ACC_DEF,
  parameter int unsigned T_SU  = T_SU_DEF,
  parameter int unsigned T_HLD = T_HLD_DEF
) (
  input  logic                  SIM_CLK,
  input  logic                  SIM_RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [1:0]            req_be,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  mram_e_n,
  output logic                  mram_g_n,
  output logic                  mram_w_n,
  output logic                  mram_lb_n,
  output logic                  mram_ub_n,
  output logic [DEV_ADDR_W-1:0] mram_addr,
  output logic [DATA_W-1:0]     mram_dq_out,
  output logic                  mram_dq_oe,
  input  logic [DATA_W-1:0]     mram_dq_in,
  output logic                  busy
);

  mram_state_e       r_state;
  logic [DATA_W-1:0] r_cap;
  logic              w_load;
  logic [TCNT_W-1:0] w_load_val;
  logic              w_zero;

  // The timer is reloaded on the same edge that enters the phase it times;
  // IDLE keeps it primed for whichever access might be accepted next.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      IDLE: begin
        w_load     = 1'b1;
        w_load_val = req_write ? phase_load(T_SU) : phase_load(T_ACC);
      end
      WR_SU: begin
        w_load     = w_zero;
        w_load_val = phase_load(T_ACC);
      end
      WR_PULSE: begin
        w_load     = w_zero;
        w_load_val = phase_load(T_HLD);
      end
      default: ;
    endcase
  end

  mram_tcount u_tcount (
    .i_clk      (SIM_CLK),
    .i_rst      (SIM_RST),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_state     <= IDLE;
      r_cap       <= '0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      mram_e_n    <= 1'b1;
      mram_g_n    <= 1'b1;
      mram_w_n    <= 1'b1;
      mram_lb_n   <= 1'b1;
      mram_ub_n   <= 1'b1;
      mram_addr   <= '0;
      mram_dq_out <= '0;
      mram_dq_oe  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            mram_e_n  <= 1'b0;
            mram_addr <= DEV_ADDR_W'(req_addr);
            if (req_write) begin
              r_state     <= WR_SU;
              mram_dq_out <= req_wdata;
              mram_dq_oe  <= 1'b1;
              mram_lb_n   <= ~req_be[0];
              mram_ub_n   <= ~req_be[1];
            end else begin
              r_state   <= RD_ACC;
              mram_g_n  <= 1'b0;
              mram_lb_n <= 1'b0;
              mram_ub_n <= 1'b0;
            end
          end
        end
        RD_ACC: begin
          if (w_zero) begin
            r_state   <= RD_DONE;
            r_cap     <= mram_dq_in;
            mram_e_n  <= 1'b1;
            mram_g_n  <= 1'b1;
            mram_lb_n <= 1'b1;
            mram_ub_n <= 1'b1;
          end
        end
        RD_DONE: begin
          r_state    <= TURN;
          resp_valid <= 1'b1;
          resp_rdata <= r_cap;
        end
        WR_SU: begin
          if (w_zero) begin
            r_state  <= WR_PULSE;
            mram_w_n <= 1'b0;
          end
        end
        WR_PULSE: begin
          if (w_zero) begin
            r_state  <= WR_HLD;
            mram_w_n <= 1'b1;
          end
        end
        WR_HLD: begin
          if (w_zero) begin
            r_state    <= TURN;
            mram_e_n   <= 1'b1;
            mram_lb_n  <= 1'b1;
            mram_ub_n  <= 1'b1;
            mram_dq_oe <= 1'b0;
          end
        end
        TURN: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mram_bus_ctrl.sv
// Bench for mram_bus_ctrl: device memory model, cycle-level behavioural
// reference with per-cycle comparison, and directed transactions.
module tb_mram_bus_ctrl;

  localparam int P_ACC  = 4;
  localparam int P_SU   = 4;
  localparam int P_HLD  = 2;
  localparam int RD_LEN = P_ACC + 2;
  localparam int WR_LEN = P_SU + P_ACC + P_HLD + 1;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b1;
  always #5 SIM_CLK = ~SIM_CLK;

  logic        req_valid, req_ready, req_write, resp_valid, busy;
  logic [11:0] req_addr;
  logic [15:0] req_wdata, resp_rdata, mram_dq_out, mram_dq_in, mram_addr;
  logic [1:0]  req_be;
  logic        mram_e_n, mram_g_n, mram_w_n, mram_lb_n, mram_ub_n, mram_dq_oe;

  logic        f_req_valid, f_req_ready, f_req_write, f_resp_valid, f_busy;
  logic [11:0] f_req_addr;
  logic [15:0] f_req_wdata, f_resp_rdata, f_dq_out, f_dq_in, f_addr;
  logic [1:0]  f_req_be;
  logic        f_e_n, f_g_n, f_w_n, f_lb_n, f_ub_n, f_dq_oe;

  mram_bus_ctrl #(.T_ACC(P_ACC), .T_SU(P_SU), .T_HLD(P_HLD)) u_dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mram_e_n(mram_e_n), .mram_g_n(mram_g_n), .mram_w_n(mram_w_n),
    .mram_lb_n(mram_lb_n), .mram_ub_n(mram_ub_n), .mram_addr(mram_addr),
    .mram_dq_out(mram_dq_out), .mram_dq_oe(mram_dq_oe), .mram_dq_in(mram_dq_in),
    .busy(busy)
  );

  mram_bus_ctrl #(.T_ACC(1), .T_SU(1), .T_HLD(1)) u_fast (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_be(f_req_be),
    .resp_valid(f_resp_valid), .resp_rdata(f_resp_rdata),
    .mram_e_n(f_e_n), .mram_g_n(f_g_n), .mram_w_n(f_w_n),
    .mram_lb_n(f_lb_n), .mram_ub_n(f_ub_n), .mram_addr(f_addr),
    .mram_dq_out(f_dq_out), .mram_dq_oe(f_dq_oe), .mram_dq_in(f_dq_in),
    .busy(f_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rv_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no DUT event within cycle budget (cycle %0d)", nm, cyc);
  endtask

  // Asynchronous MRAM: reads present the array while E_n and G_n are low,
  // writes land byte-wise on every clock that sees E_n and W_n low.
  logic [15:0] dev_mem [0:4095];
  logic [15:0] fdev_mem [0:4095];
  bit          dev_init = 1'b0;

  always @(posedge SIM_CLK) begin
    if (!dev_init) begin
      for (int i = 0; i < 4096; i++) begin
        dev_mem[i]  = 16'h0000;
        fdev_mem[i] = 16'h0000;
      end
      dev_init = 1'b1;
    end
    if (!mram_e_n && !mram_w_n) begin
      if (!mram_lb_n) dev_mem[mram_addr[11:0]][7:0]  = mram_dq_out[7:0];
      if (!mram_ub_n) dev_mem[mram_addr[11:0]][15:8] = mram_dq_out[15:8];
    end
    if (!f_e_n && !f_w_n) begin
      if (!f_lb_n) fdev_mem[f_addr[11:0]][7:0]  = f_dq_out[7:0];
      if (!f_ub_n) fdev_mem[f_addr[11:0]][15:8] = f_dq_out[15:8];
    end
  end

  always_comb begin
    mram_dq_in = 16'h0000;
    if (!mram_e_n && !mram_g_n) mram_dq_in = dev_mem[mram_addr[11:0]];
  end

  always_comb begin
    f_dq_in = 16'h0000;
    if (!f_e_n && !f_g_n) f_dq_in = fdev_mem[f_addr[11:0]];
  end

  // Reference: each accepted op is an offset j from its accept edge; the
  // expected pin values are read off the phase that offset falls in.
  bit          model_on = 1'b0;
  bit          m_init = 1'b0;
  bit          m_act = 1'b0;
  bit          m_wr = 1'b0;
  int          m_a = 0;
  logic [11:0] m_addr = '0;
  logic [15:0] m_wdata = '0, m_old = '0, m_data = '0, m_alt = '0;
  logic [1:0]  m_be = '0;
  logic [15:0] m_rdata = '0, m_ralt = '0;
  logic [15:0] m_mem [0:4095];
  bit          unc = 1'b0;
  logic [11:0] unc_addr = '0;
  logic [15:0] unc_old = '0;
  logic [5:0]  exp_strb = 6'b111110;
  logic [2:0]  exp_ctl = 3'b100;
  bit          exp_chk_addr = 1'b0, exp_chk_dq = 1'b0;

  always @(posedge SIM_CLK) begin : model
    int len, jp, j;
    cyc++;
    if (!m_init) begin
      for (int i = 0; i < 4096; i++) m_mem[i] = 16'h0000;
      m_init = 1'b1;
    end
    len = m_wr ? WR_LEN : RD_LEN;
    jp  = cyc - 1 - m_a;
    if (SIM_RST) begin
      if (m_act && m_wr && jp < len) begin
        unc = 1'b1; unc_addr = m_addr; unc_old = m_old;
      end
      m_act = 1'b0; m_rdata = '0; m_ralt = '0; model_on = 1'b1;
    end else begin
      if (!(m_act && jp < len) && req_valid) begin
        m_act = 1'b1; m_a = cyc; m_wr = req_write; m_addr = req_addr;
        m_wdata = req_wdata; m_be = req_be;
        if (req_write) begin
          m_old = m_mem[req_addr];
          if (req_be[0]) m_mem[req_addr][7:0]  = req_wdata[7:0];
          if (req_be[1]) m_mem[req_addr][15:8] = req_wdata[15:8];
          if (unc && unc_addr == req_addr) unc = 1'b0;
        end else begin
          m_data = m_mem[req_addr];
          m_alt  = (unc && unc_addr == req_addr) ? unc_old : m_data;
        end
        len = m_wr ? WR_LEN : RD_LEN;
      end
      if (m_act && !m_wr && cyc - m_a == P_ACC + 1) begin
        m_rdata = m_data; m_ralt = m_alt;
      end
    end
    j = cyc - m_a;
    exp_strb = 6'b111110; exp_ctl = 3'b100; exp_chk_addr = 1'b0; exp_chk_dq = 1'b0;
    if (m_act && j < len) begin
      exp_ctl = 3'b010;
      if (!m_wr) begin
        if (j < P_ACC) begin
          exp_strb = 6'b001000; exp_chk_addr = 1'b1;
        end else if (j == P_ACC + 1) begin
          exp_ctl = 3'b011;
        end
      end else if (j < len - 1) begin
        exp_strb = {1'b0, 1'b1, !(j >= P_SU && j < P_SU + P_ACC), ~m_be[0], ~m_be[1], 1'b1};
        exp_chk_addr = 1'b1; exp_chk_dq = 1'b1;
      end
    end
  end

  always @(negedge SIM_CLK) begin
    if (model_on) begin
      chk("strobes", 32'({mram_e_n, mram_g_n, mram_w_n, mram_lb_n, mram_ub_n, mram_dq_oe}),
          32'(exp_strb));
      chk("ready_busy_rvalid", 32'({req_ready, busy, resp_valid}), 32'(exp_ctl));
      checks++;
      if (resp_rdata !== m_rdata && resp_rdata !== m_ralt) begin
        errors++;
        $display("FAIL resp_rdata: got %0h expected %0h or %0h (cycle %0d)",
                 resp_rdata, m_rdata, m_ralt, cyc);
      end
      if (exp_chk_addr) chk("mram_addr", 32'(mram_addr), 32'({4'h0, m_addr}));
      if (exp_chk_dq) chk("mram_dq_out", 32'(mram_dq_out), 32'(m_wdata));
      chk("g_w_overlap", 32'(!mram_g_n && !mram_w_n), 32'd0);
      chk("oe_during_read", 32'(mram_dq_oe && !mram_g_n), 32'd0);
      chk("fast_g_w_overlap", 32'(!f_g_n && !f_w_n), 32'd0);
      if (resp_valid) rv_count++;
    end
  end

  a_no_gw: assert property (@(posedge SIM_CLK) disable iff (SIM_RST) !(!mram_g_n && !mram_w_n))
    else begin
      errors++;
      $display("FAIL assert_g_w_overlap: G_n and W_n both low (cycle %0d)", cyc);
    end

  task automatic issue(input logic wr, input logic [11:0] ad, input logic [15:0] wd,
                       input logic [1:0] be, output int acc);
    logic rdy;
    acc = -1;
    req_valid = 1'b1; req_write = wr; req_addr = ad; req_wdata = wd; req_be = be;
    for (int i = 0; i < 64; i++) begin
      rdy = req_ready;
      @(posedge SIM_CLK); #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) timeout("accept");
  endtask

  // Drops valid and scribbles over the request fields while the op runs.
  task automatic scramble();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 12'($urandom);
    req_wdata = 16'($urandom);
    req_be    = 2'($urandom);
  endtask

  task automatic wait_resp(output int at, output logic [15:0] d);
    at = -1; d = '0;
    for (int i = 0; i < 64; i++) begin
      @(posedge SIM_CLK); #1;
      if (resp_valid) begin
        at = cyc; d = resp_rdata;
        break;
      end
    end
    if (at < 0) timeout("resp_valid");
  endtask

  task automatic f_issue(input logic wr, input logic [11:0] ad, input logic [15:0] wd,
                         output int acc);
    logic rdy;
    acc = -1;
    f_req_valid = 1'b1; f_req_write = wr; f_req_addr = ad; f_req_wdata = wd; f_req_be = 2'b11;
    for (int i = 0; i < 64; i++) begin
      rdy = f_req_ready;
      @(posedge SIM_CLK); #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    f_req_valid = 1'b0;
    if (acc < 0) timeout("fast_accept");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          a, a2, a3, r, rv0;
    logic [15:0] d;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    f_req_valid = 1'b0; f_req_write = 1'b0; f_req_addr = '0; f_req_wdata = '0; f_req_be = '0;
    SIM_RST = 1'b1;
    repeat (3) @(posedge SIM_CLK);
    #1;
    SIM_RST = 1'b0;

    chk("reset_ready_busy", 32'({req_ready, busy, resp_valid}), 32'b100);
    chk("reset_strobes", 32'({mram_e_n, mram_g_n, mram_w_n, mram_lb_n, mram_ub_n, mram_dq_oe}),
        32'b111110);
    chk("reset_addr_dq", 32'({mram_addr, mram_dq_out}), 32'd0);
    chk("reset_rdata", 32'(resp_rdata), 32'd0);

    issue(1'b1, 12'h005, 16'hBEEF, 2'b11, a);
    scramble();
    issue(1'b0, 12'h005, 16'h0000, 2'b00, a);
    scramble();
    wait_resp(r, d);
    chk("wr_rd_latency", 32'(r - a), 32'd5);
    chk("wr_rd_data", 32'(d), 32'hBEEF);

    issue(1'b1, 12'h010, 16'h1234, 2'b11, a);
    scramble();
    issue(1'b1, 12'h010, 16'hABCD, 2'b01, a);
    scramble();
    issue(1'b0, 12'h010, 16'h0000, 2'b00, a);
    scramble();
    wait_resp(r, d);
    chk("byte_write_data", 32'(d), 32'h12CD);

    issue(1'b1, 12'h010, 16'h5555, 2'b00, a);
    scramble();
    issue(1'b0, 12'h010, 16'h0000, 2'b00, a);
    scramble();
    wait_resp(r, d);
    chk("be00_no_write", 32'(d), 32'h12CD);

    issue(1'b1, 12'h020, 16'hA020, 2'b11, a);
    issue(1'b1, 12'h021, 16'hA021, 2'b11, a);
    issue(1'b1, 12'h022, 16'hA022, 2'b11, a);
    scramble();
    repeat (WR_LEN + 2) @(posedge SIM_CLK);
    #1;
    rv0 = rv_count;
    issue(1'b0, 12'h020, 16'h0000, 2'b00, a);
    issue(1'b0, 12'h021, 16'h0000, 2'b00, a2);
    issue(1'b0, 12'h022, 16'h0000, 2'b00, a3);
    scramble();
    repeat (RD_LEN + 3) @(posedge SIM_CLK);
    #1;
    chk("b2b_resp_count", 32'(rv_count - rv0), 32'd3);
    chk("b2b_spacing_1", 32'(a2 - a), 32'd7);
    chk("b2b_spacing_2", 32'(a3 - a2), 32'd7);

    issue(1'b1, 12'h030, 16'h1111, 2'b11, a);
    scramble();
    issue(1'b1, 12'h030, 16'h7777, 2'b11, a);
    scramble();
    repeat (5) @(posedge SIM_CLK);
    #1;
    chk("pulse_w_low", 32'({mram_e_n, mram_w_n}), 32'b00);
    SIM_RST = 1'b1;
    @(posedge SIM_CLK); #1;
    chk("reset_mid_pulse", 32'({mram_e_n, mram_g_n, mram_w_n, mram_lb_n, mram_ub_n, mram_dq_oe}),
        32'b111110);
    chk("reset_mid_pulse_rv", 32'({busy, resp_valid}), 32'b00);
    SIM_RST = 1'b0;
    issue(1'b0, 12'h030, 16'h0000, 2'b00, a);
    scramble();
    wait_resp(r, d);
    chk("reset_read_old_or_new", 32'(d == 16'h1111 || d == 16'h7777), 32'd1);

    f_issue(1'b1, 12'hFFF, 16'h0F0F, a);
    f_issue(1'b0, 12'hFFF, 16'h0000, a);
    r = -1;
    for (int i = 0; i < 32; i++) begin
      @(posedge SIM_CLK); #1;
      if (f_resp_valid) begin
        r = cyc; d = f_resp_rdata;
        break;
      end
    end
    if (r < 0) timeout("fast_resp_valid");
    else begin
      chk("fast_latency", 32'(r - a), 32'd2);
      chk("fast_data", 32'(d), 32'h0F0F);
    end
    repeat (3) @(posedge SIM_CLK);
    #1;
    chk("fast_idle", 32'({f_req_ready, f_busy}), 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mram_bus_ctrl.md
MRAM_BUS_CTRL -- requirements
Module: mram_bus_ctrl

Interface
REQ-001 SHALL have parameter T_ACC, default 4: cycles the read-enable (G_n) or write-enable (W_n) strobe is held low, range 1-15.
REQ-002 SHALL have parameter T_SU, default 4: write data/address setup cycles before the W_n fall, range 1-15.
REQ-003 SHALL have parameter T_HLD, default 2: write hold cycles after the W_n rise, range 1-15.
REQ-004 SHALL have port SIM_CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port SIM_RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-008 SHALL have port req_write  in  1  1=write, 0=read.
REQ-009 SHALL have port req_addr  in  12  word address.
REQ-010 SHALL have port req_wdata  in  16  write data.
REQ-011 SHALL have port req_be  in  2  byte enables: [0]=low byte, [1]=upper byte.
REQ-012 SHALL have port resp_valid  out  1  one-cycle read-data strobe.
REQ-013 SHALL have port resp_rdata  out  16  read data.
REQ-014 SHALL have ports mram_e_n, mram_g_n, mram_w_n, mram_lb_n, mram_ub_n  out  1 each  device strobes, active-low.
REQ-015 SHALL have port mram_addr  out  16  device address; bits 15:12 always 0.
REQ-016 SHALL have ports mram_dq_out (out, 16) and mram_dq_oe (out, 1): write data and its tri-state enable.
REQ-017 SHALL have port mram_dq_in  in  16  device data bus sampled on reads.
REQ-018 SHALL have port busy  out  1  FSM not in IDLE.

Function
REQ-019 FSM states SHALL be IDLE, RD_ACC, RD_DONE, WR_SU, WR_PULSE, WR_HLD, TURN; all outputs SHALL be registered.
REQ-020 req_ready SHALL be 1 only in IDLE; on acceptance, addr/wdata/be SHALL be latched and req_* ignored until the FSM returns to IDLE.
REQ-021 Read: IDLE->RD_ACC drives E_n=0, G_n=0, W_n=1, LB_n=UB_n=0, dq_oe=0 for T_ACC cycles; mram_dq_in SHALL be sampled on the last RD_ACC cycle; RD_DONE raises all strobes and sets resp_valid=1 for exactly 1 cycle; then TURN (1 cycle) -> IDLE.
REQ-022 Read latency SHALL be T_ACC+1 cycles from the accept edge to resp_valid high.
REQ-023 Write: WR_SU (T_SU cycles: E_n=0, G_n=1, W_n=1, dq_oe=1, LB_n=~be[0], UB_n=~be[1]); WR_PULSE (T_ACC cycles: W_n=0); WR_HLD (T_HLD cycles: W_n=1, E_n=0, dq_oe=1); then TURN -> IDLE.
REQ-024 A write SHALL produce no resp_valid.
REQ-025 mram_g_n and mram_w_n SHALL never both be 0 in the same cycle.
REQ-026 mram_dq_oe SHALL never be 1 while mram_g_n=0.
REQ-027 mram_addr and mram_dq_out SHALL remain constant from the first WR_SU cycle through the last WR_HLD cycle.
REQ-028 With the defaults at a 10 ns SIM_CLK, the 40 ns setup and strobe widths SHALL exceed the device's 30 ns internal delay.
REQ-029 TURN SHALL hold all strobes high and dq_oe=0, giving at least 1 idle cycle between back-to-back operations.
REQ-030 be=2'b00 on a write SHALL still run the full sequence with LB_n=UB_n=1 (no byte written).
REQ-031 resp_rdata SHALL hold its last value until the next read completes.

Reset
REQ-032 On SIM_RST high at an edge: FSM->IDLE; E_n=G_n=W_n=LB_n=UB_n=1; dq_oe=0; mram_addr=0; mram_dq_out=0; resp_valid=0; resp_rdata=0; busy=0; req_ready=1 from the first cycle after reset deasserts.
REQ-033 Reset mid-operation SHALL abandon the access with no resp_valid, and all strobes SHALL rise in the same cycle.

Structure
REQ-034 A shared package mram_pkg SHALL hold the state enum, the address/data width constants (12, 16) and the T_* defaults.
REQ-035 One sub-module, mram_tcount (4-bit load/decrement phase timer with a zero flag), SHALL time all phases.

Verification
REQ-036 Write then read: write addr=0x005, data=0xBEEF, be=11, then read 0x005 -> resp_rdata=0xBEEF exactly 5 cycles after the read is accepted.
REQ-037 Byte write: after 0x1234 is written at 0x010, write 0xABCD with be=01, then read -> 0x12CD.
REQ-038 Back-to-back: req_valid held high with 3 queued reads -> exactly 3 resp_valid pulses, each op separated by a TURN cycle, and a concurrent assertion never sees G_n=0 && W_n=0.
REQ-039 Reset in WR_PULSE (cycle 2 of pulse) -> next cycle all strobes are 1 and dq_oe=0; a subsequent read of that address returns either the old or the new data, and the simulation does not terminate.
REQ-040 Parameters T_SU=1, T_ACC=1, T_HLD=1: a write of 0x0F0F at 0xFFF followed by a read returns 0x0F0F, with read latency 2 cycles.
